// File: rtl/cordic_phase_scheduler.sv
// Round-robin scheduler that shares one atan2 CORDIC engine between N_CH demodulator
// channels: one-deep sample slot per channel, start/done handshake with watchdog, tagged result.
module cordic_phase_scheduler #(
    parameter int N_CH      = 4,
    parameter int BIT_WIDTH = 24,
    parameter int TIMEOUT   = 63
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [N_CH-1:0]                     ch_valid_i,
    input  logic [N_CH-1:0][BIT_WIDTH-1:0]      ch_sin_i,
    input  logic [N_CH-1:0][BIT_WIDTH-1:0]      ch_cos_i,
    input  logic                                clear_flags_i,
    output logic                                cordic_start_o,
    output logic signed [BIT_WIDTH-1:0]         cordic_sin_o,
    output logic signed [BIT_WIDTH-1:0]         cordic_cos_o,
    input  logic signed [BIT_WIDTH-1:0]         cordic_phi_i,
    input  logic                                cordic_done_i,
    output logic signed [BIT_WIDTH-1:0]         phi_o,
    output logic [$clog2(N_CH)-1:0]             phi_ch_o,
    output logic                                phi_valid_o,
    output logic                                busy_o,
    output logic [N_CH-1:0]                     overrun_o,
    output logic                                timeout_o
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               rr_q, rr_d;
    logic [CW-1:0]               gnt_q, gnt_d;
    logic [TW-1:0]               cnt_q, cnt_d;
    logic [N_CH-1:0]             pend_q, pend_d;
    logic [N_CH-1:0]             ovr_q, ovr_d, ovr_set;
    logic                        tmo_q, tmo_d, tmo_set;
    logic signed [BIT_WIDTH-1:0] op_sin_q, op_sin_d;
    logic signed [BIT_WIDTH-1:0] op_cos_q, op_cos_d;
    logic signed [BIT_WIDTH-1:0] phi_q, phi_d;
    logic [CW-1:0]               phi_ch_q, phi_ch_d;
    logic                        phi_vld_q, phi_vld_d;

    logic signed [BIT_WIDTH-1:0] slot_sin_q [N_CH];
    logic signed [BIT_WIDTH-1:0] slot_cos_q [N_CH];

    logic                        gnt_found;
    logic [CW-1:0]               gnt_idx;
    logic [CW-1:0]               cand;
    logic                        grant_now;

    // First pending channel after the last grant, wrapping; gives 0,1,..,N_CH-1 under full load.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CW'((int'(rr_q) + i) % N_CH);
            if (!gnt_found && pend_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        op_sin_d  = op_sin_q;
        op_cos_d  = op_cos_q;
        phi_d     = phi_q;
        phi_ch_d  = phi_ch_q;
        phi_vld_d = 1'b0;
        tmo_set   = 1'b0;
        grant_now = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    grant_now = 1'b1;
                    gnt_d     = gnt_idx;
                    rr_d      = gnt_idx;
                    op_sin_d  = slot_sin_q[gnt_idx];
                    op_cos_d  = slot_cos_q[gnt_idx];
                    state_d   = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + TW'(1);
                // A done level left over from the previous op is ignored on the first WAIT cycle.
                if (cordic_done_i && (cnt_q != '0)) begin
                    phi_d     = cordic_phi_i;
                    phi_ch_d  = gnt_q;
                    phi_vld_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A strobe on the channel being granted refills its slot without counting as an overrun.
    always_comb begin
        pend_d  = pend_q;
        ovr_set = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_now && (gnt_idx == CW'(k))) begin
                pend_d[k] = ch_valid_i[k];
            end else if (ch_valid_i[k]) begin
                pend_d[k]  = 1'b1;
                ovr_set[k] = pend_q[k];
            end
        end
        ovr_d = (ovr_q & ~{N_CH{clear_flags_i}}) | ovr_set;
        tmo_d = (tmo_q & ~clear_flags_i) | tmo_set;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            rr_q      <= CW'(N_CH - 1);
            gnt_q     <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
            tmo_q     <= 1'b0;
            op_sin_q  <= '0;
            op_cos_q  <= '0;
            phi_q     <= '0;
            phi_ch_q  <= '0;
            phi_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            tmo_q     <= tmo_d;
            op_sin_q  <= op_sin_d;
            op_cos_q  <= op_cos_d;
            phi_q     <= phi_d;
            phi_ch_q  <= phi_ch_d;
            phi_vld_q <= phi_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_CH; k++) begin
            if (ch_valid_i[k]) begin
                slot_sin_q[k] <= ch_sin_i[k];
                slot_cos_q[k] <= ch_cos_i[k];
            end
        end
    end

    assign cordic_start_o = (state_q == S_START);
    assign busy_o         = (state_q != S_IDLE);
    assign cordic_sin_o   = op_sin_q;
    assign cordic_cos_o   = op_cos_q;
    assign phi_o          = phi_q;
    assign phi_ch_o       = phi_ch_q;
    assign phi_valid_o    = phi_vld_q;
    assign overrun_o      = ovr_q;
    assign timeout_o      = tmo_q;

endmodule

// File: tb/tb_cordic_phase_scheduler.sv
// Bench for cordic_phase_scheduler: behavioural CORDIC engine, transaction-level
// scheduler model compared every cycle, directed scenarios plus randomized traffic.
module tb_cordic_phase_scheduler;

    localparam int N  = 4;
    localparam int BW = 24;
    localparam int TO = 63;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           ch_valid = '0;
    logic [N-1:0][BW-1:0]   ch_sin = '0;
    logic [N-1:0][BW-1:0]   ch_cos = '0;
    logic                   clear = 1'b0;
    logic                   cordic_start_o;
    logic [BW-1:0]          cordic_sin_o, cordic_cos_o;
    logic [BW-1:0]          cordic_phi = '0;
    logic                   cordic_done = 1'b0;
    logic [BW-1:0]          phi_o;
    logic [1:0]             phi_ch_o;
    logic                   phi_valid_o, busy_o, timeout_o;
    logic [N-1:0]           overrun_o;

    int checks = 0;
    int failures = 0;

    cordic_phase_scheduler #(.N_CH(N), .BIT_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(rst), .ch_valid_i(ch_valid), .ch_sin_i(ch_sin), .ch_cos_i(ch_cos),
        .clear_flags_i(clear), .cordic_start_o(cordic_start_o), .cordic_sin_o(cordic_sin_o),
        .cordic_cos_o(cordic_cos_o), .cordic_phi_i(cordic_phi), .cordic_done_i(cordic_done),
        .phi_o(phi_o), .phi_ch_o(phi_ch_o), .phi_valid_o(phi_valid_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .timeout_o(timeout_o));

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- CORDIC engine stand-in ----------------
    // mode 0: done pulse after lat cycles; 1: never done; 2: done level held, stale through first WAIT cycle
    int eng_mode = 0;
    int eng_lmin = 2;
    int eng_lmax = 2;

    function automatic logic [BW-1:0] phi_fn(logic [BW-1:0] s, logic [BW-1:0] c);
        return s + (c & 24'h00FFFF);
    endfunction

    initial begin : engine
        int cnt;
        bit fresh, st;
        logic [BW-1:0] os, oc, ss, sc;
        cnt = 0; fresh = 0; os = '0; oc = '0;
        forever begin
            @(posedge clk);
            st = cordic_start_o; ss = cordic_sin_o; sc = cordic_cos_o;
            #1;
            if (rst) begin
                cordic_done = 1'b0; cnt = 0; fresh = 0;
                continue;
            end
            if (eng_mode == 0) cordic_done = 1'b0;
            if (st) begin
                os = ss; oc = sc;
                cnt = $urandom_range(eng_lmin, eng_lmax);
                fresh = (eng_mode == 2);
                if (eng_mode != 2) cordic_done = 1'b0;
            end else if (cnt > 0) begin
                if (fresh) begin cordic_done = 1'b0; fresh = 0; end
                cnt--;
                if (cnt == 0 && eng_mode != 1) begin
                    cordic_done = 1'b1;
                    cordic_phi  = phi_fn(os, oc);
                end
            end
        end
    end

    // ---------------- behavioural scheduler model ----------------
    bit            m_pend [N];
    logic [BW-1:0] m_sin [N], m_cos [N];
    int            m_rr;
    bit            e_start, e_busy, e_pv, e_tmo;
    bit [N-1:0]    e_ovr;
    logic [BW-1:0] e_osin, e_ocos, e_phi;
    int            e_pch;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin m_pend[k] = 0; m_sin[k] = '0; m_cos[k] = '0; end
        m_rr = N - 1;
        e_start = 0; e_busy = 0; e_pv = 0; e_tmo = 0; e_ovr = '0;
        e_osin = '0; e_ocos = '0; e_phi = '0; e_pch = 0;
    endfunction

    function automatic int pick();
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    // Apply this edge's channel strobes and flag clear; gch is the channel granted at this edge.
    function automatic void absorb(int gch, bit tmo_set);
        bit [N-1:0] setv;
        setv = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_valid[k]) begin
                if (m_pend[k] && k != gch) setv[k] = 1'b1;
                m_pend[k] = 1; m_sin[k] = ch_sin[k]; m_cos[k] = ch_cos[k];
            end
        end
        if (clear) begin e_ovr = '0; e_tmo = 0; end
        e_ovr |= setv;
        if (tmo_set) e_tmo = 1;
    endfunction

    task automatic tick(output bit r);
        @(posedge clk);
        r = rst;
        if (r) model_reset();
    endtask

    initial begin : model
        bit r, fin;
        int g, n;
        model_reset();
        forever begin
            tick(r);
            if (r) continue;
            e_pv = 0;
            g = pick();
            if (g < 0) begin absorb(-1, 0); continue; end
            e_osin = m_sin[g]; e_ocos = m_cos[g]; m_rr = g; m_pend[g] = 0;
            absorb(g, 0);
            e_start = 1; e_busy = 1;
            tick(r);
            if (r) continue;
            e_start = 0;
            absorb(-1, 0);
            n = 0; fin = 0;
            while (!fin) begin
                tick(r);
                if (r) break;
                if (cordic_done && n >= 1) begin
                    e_phi = cordic_phi; e_pch = g; e_pv = 1; e_busy = 0; fin = 1;
                    absorb(-1, 0);
                end else if (n == TO - 1) begin
                    e_busy = 0; fin = 1;
                    absorb(-1, 1);
                end else begin
                    absorb(-1, 0);
                end
                n++;
            end
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int            start_cnt = 0;
    int            pv_cnt = 0;
    int            pv_q [$];
    logic [BW-1:0] iss_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("start", cordic_start_o, e_start);
            chk("busy", busy_o, e_busy);
            chk("phi_valid", phi_valid_o, e_pv);
            chk("op_sin", cordic_sin_o, e_osin);
            chk("op_cos", cordic_cos_o, e_ocos);
            chk("phi", phi_o, e_phi);
            chk("phi_ch", phi_ch_o, e_pch);
            chk("overrun", overrun_o, e_ovr);
            chk("timeout", timeout_o, e_tmo);
            if (cordic_start_o) begin start_cnt++; iss_q.push_back(cordic_sin_o); end
            if (phi_valid_o) begin pv_cnt++; pv_q.push_back(int'(phi_ch_o)); end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        ch_valid = '0; clear = 0; rst = 1;
        cyc(); cyc();
        rst = 0;
        cyc();
    endtask

    task automatic wait_pv(int target, int budget, string nm);
        int b;
        b = 0;
        while (pv_cnt < target && b < budget) begin cyc(); b++; end
        chk(nm, pv_cnt, target);
    endtask

    initial begin : stim
        int base, n, a_seen;
        do_reset();
        chk("reset_busy", busy_o, 0);
        chk("reset_overrun", overrun_o, 0);

        // single request on ch2, result 0
        eng_mode = 0; eng_lmin = 2; eng_lmax = 2;
        ch_valid = 4'b0100; ch_sin[2] = 24'd0; ch_cos[2] = 24'd4194304;
        cyc(); ch_valid = '0;
        chk("t1_no_start_yet", cordic_start_o, 0);
        cyc();
        chk("t1_start", cordic_start_o, 1);
        chk("t1_op_cos", cordic_cos_o, 24'd4194304);
        cyc();
        chk("t1_start_one_cycle", cordic_start_o, 0);
        wait_pv(1, 50, "t1_phi_valid");
        chk("t1_phi", phi_o, 0);
        chk("t1_phi_ch", phi_ch_o, 2);

        // all four channels in the same cycle
        do_reset();
        eng_lmin = 1; eng_lmax = 4;
        base = pv_q.size();
        for (int k = 0; k < N; k++) begin ch_sin[k] = BW'($urandom); ch_cos[k] = BW'($urandom); end
        ch_valid = 4'b1111;
        cyc(); ch_valid = '0;
        wait_pv(pv_cnt + 4, 200, "t2_four_results");
        for (int i = 0; i < 4; i++) chk("t2_order", (pv_q.size() > base + i) ? pv_q[base + i] : -1, i);
        chk("t2_no_overrun", overrun_o, 0);

        // ch1 overwritten while engine busy with ch0
        do_reset();
        eng_lmin = 6; eng_lmax = 6;
        base = iss_q.size();
        ch_valid = 4'b0001; ch_sin[0] = 24'h0ABCDE;
        cyc(); ch_valid = '0;
        cyc();
        ch_valid = 4'b0010; ch_sin[1] = 24'h111111;
        cyc(); ch_sin[1] = 24'h222222;
        cyc(); ch_valid = '0;
        wait_pv(pv_cnt + 2, 200, "t3_two_results");
        chk("t3_overrun1", overrun_o, 4'b0010);
        chk("t3_issued_B", iss_q[$], 24'h222222);
        a_seen = 0;
        for (int i = base; i < iss_q.size(); i++) if (iss_q[i] == 24'h111111) a_seen++;
        chk("t3_A_never_issued", a_seen, 0);
        clear = 1;
        cyc(); clear = 0;
        chk("t3_overrun_cleared", overrun_o, 0);

        // watchdog: engine never answers ch0, ch3 waits behind it
        eng_mode = 1; eng_lmin = 2; eng_lmax = 2;
        base = pv_cnt;
        ch_valid = 4'b0001; ch_sin[0] = 24'h000321;
        cyc(); ch_valid = 4'b1000; ch_sin[3] = 24'h000333;
        cyc(); ch_valid = '0;
        n = 0;
        while (!cordic_start_o && n < 20) begin cyc(); n++; end
        n = 0;
        while (busy_o && n < 200) begin n++; cyc(); end
        chk("t4_busy_cycles", n, 1 + TO);
        chk("t4_timeout", timeout_o, 1);
        chk("t4_no_phi", pv_cnt, base);
        eng_mode = 0;
        wait_pv(base + 1, 100, "t4_next_served");
        chk("t4_next_ch", phi_ch_o, 3);

        // done held high from the previous op
        do_reset();
        eng_mode = 2; eng_lmin = 1; eng_lmax = 4;
        for (int i = 0; i < 6; i++) begin
            int c;
            c = $urandom_range(0, N - 1);
            ch_sin[c] = BW'($urandom); ch_cos[c] = BW'($urandom);
            ch_valid = '0; ch_valid[c] = 1'b1;
            base = pv_cnt;
            cyc(); ch_valid = '0;
            wait_pv(base + 1, 100, "t5_one_result");
            cyc(); cyc();
            chk("t5_exactly_one", pv_cnt, base + 1);
        end

        // randomized traffic
        eng_lmin = 1; eng_lmax = 8;
        for (int t = 0; t < 1500; t++) begin
            logic [N-1:0] v;
            eng_mode = (t / 150) % 3;
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 5) == 0);
                ch_sin[k] = BW'($urandom); ch_cos[k] = BW'($urandom);
            end
            ch_valid = v;
            clear = ($urandom_range(0, 24) == 0);
            cyc();
        end
        ch_valid = '0; clear = 0; eng_mode = 0;
        for (int t = 0; t < 300; t++) cyc();

        // reset in WAIT with ch3 pending
        do_reset();
        eng_mode = 1;
        ch_valid = 4'b0001; ch_sin[0] = 24'h123456; ch_cos[0] = 24'h654321;
        cyc(); ch_valid = 4'b1000;
        cyc(); ch_valid = '0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t7_busy_before", busy_o, 1);
        rst = 1;
        #1;
        chk("t7_busy", busy_o, 0);
        chk("t7_start", cordic_start_o, 0);
        chk("t7_op_sin", cordic_sin_o, 0);
        chk("t7_op_cos", cordic_cos_o, 0);
        chk("t7_phi_valid", phi_valid_o, 0);
        chk("t7_overrun", overrun_o, 0);
        chk("t7_timeout", timeout_o, 0);
        cyc(); cyc();
        rst = 0;
        base = start_cnt;
        for (int i = 0; i < 10; i++) cyc();
        chk("t7_no_start_after", start_cnt, base);
        chk("t7_idle_after", busy_o, 0);
        eng_mode = 0; eng_lmin = 2; eng_lmax = 3;
        base = pv_cnt;
        ch_valid = 4'b0010; ch_sin[1] = 24'h00F00D;
        cyc(); ch_valid = '0;
        wait_pv(base + 1, 100, "t7_served_after");
        chk("t7_ch", phi_ch_o, 1);

        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
